cla_nibble_seq_ctrl: RTL

//  Sequencer that performs WIDTH-bit additions on one shared 4-bit carry-lookahead adder.

---
 rtl/cla_nibble_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cla_nibble_seq_ctrl.sv
// cla_nibble_seq_ctrl: performs WIDTH-bit additions through one external 4-bit
// carry-lookahead adder. Operands arrive over a valid/ready handshake. One
// nibble is processed per cycle, LSB nibble first, and the carry is chained
// between nibbles. The full sum/cout is then offered on a valid/ready output.
// Optional build macro: OVERFLOW_FLAG_EN adds the signed overflow output ovf.
module cla_nibble_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_idle;
  logic [3:0]       w_add_a;
  logic [3:0]       w_add_b;
`ifdef OVERFLOW_FLAG_EN
  logic             r_ovf;
`endif

  // The idle flag resets to 1. It is gated with rst_n so that in_ready is low
  // while reset is held and rises as soon as reset releases.
  assign in_ready  = r_idle & rst_n;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign add_a     = w_add_a;
  assign add_b     = w_add_b;
  assign add_cin   = (r_state == S_RUN) & r_carry;
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = r_ovf;
`endif

  // Select the current operand nibbles for the adder (zero outside RUN)
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    if (r_state == S_RUN) begin
      for (int unsigned n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDXW'(n)) begin
          w_add_a = r_a[4*n +: 4];
          w_add_b = r_b[4*n +: 4];
        end
      end
    end
  end

  // Sequencer FSM: accept operands, step through the nibbles, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_idle      <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
            r_idle  <= 1'b0;
            r_state <= S_RUN;
`ifdef OVERFLOW_FLAG_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) begin
              r_sum[4*n +: 4] <= add_s;
            end
          end
          r_carry <= add_cout;
          if (r_idx == LAST_IDX) begin
            r_idx       <= '0;
            r_cout      <= add_cout;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef OVERFLOW_FLAG_EN
            // Overflow: carry out of the MSB differs from the carry into it
            r_ovf       <= add_cout ^ (w_add_a[3] ^ w_add_b[3] ^ add_s[3]);
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idle      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
